// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/host memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_WIDTH = 8;
    localparam int ARB_DATA_WIDTH = 16;

    // Access sequencer states: wait for a request, drive the RAM, take the result.
    typedef enum logic [1:0] {
        ARB_STATE_IDLE    = 2'd0,
        ARB_STATE_ISSUE   = 2'd1,
        ARB_STATE_CAPTURE = 2'd2
    } arb_state_e;

    // Grant encoding, also used as the index of the port inside the request vector.
    localparam logic ARB_GRANT_CPU  = 1'b0;
    localparam logic ARB_GRANT_HOST = 1'b1;

    // Two-way round-robin choice: a lone requester wins; on a tie the port that
    // did not win last time is chosen.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        case (req)
            2'b01:   pick = ARB_GRANT_CPU;
            2'b10:   pick = ARB_GRANT_HOST;
            2'b11:   pick = ~last_grant;
            default: pick = ARB_GRANT_CPU;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational 2-way round-robin picker. Bit 0 of the request vector is the
// CPU port, bit 1 the host port.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_valid
);

    // Pick a winner whenever any port is requesting.
    always_comb begin
        o_valid = |i_req;
        o_grant = rr_pick(i_req, i_last_grant);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU and a host debug port.
// Each access takes IDLE -> ISSUE (mem_en) -> CAPTURE (ack, read data bypass).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_read_not_write,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_ack,
    input  logic                  i_host_req,
    input  logic                  i_host_read_not_write,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_ack,
    output logic                  o_mem_en,
    output logic                  o_mem_read_not_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic                  w_latch;
    logic                  w_pick_grant;
    logic                  w_pick_valid;
    logic                  w_sel_rnw;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_cap_read;

    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_rnw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_mem_en;
    logic                  r_cpu_ack;
    logic                  r_host_ack;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_host_rdata;

    arb_rr2 u_arb_rr2 (
        .i_req        ({i_host_req, i_cpu_req}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    // Next-state logic; the access fields are captured only when leaving IDLE.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ARB_STATE_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = ARB_STATE_ISSUE;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = ARB_STATE_IDLE;
                end
            end
            ARB_STATE_ISSUE:   w_next_state = ARB_STATE_CAPTURE;
            ARB_STATE_CAPTURE: w_next_state = ARB_STATE_IDLE;
            default:           w_next_state = ARB_STATE_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ARB_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Select the fields of the port that is about to be granted.
    always_comb begin
        if (w_pick_grant == ARB_GRANT_HOST) begin
            w_sel_rnw   = i_host_read_not_write;
            w_sel_addr  = i_host_addr;
            w_sel_wdata = i_host_wdata;
        end else begin
            w_sel_rnw   = i_cpu_read_not_write;
            w_sel_addr  = i_cpu_addr;
            w_sel_wdata = i_cpu_wdata;
        end
    end

    // Latch grant and access fields so requester changes mid-access are ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= ARB_GRANT_HOST;
            r_grant      <= ARB_GRANT_CPU;
            r_rnw        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_latch) begin
            r_last_grant <= w_pick_grant;
            r_grant      <= w_pick_grant;
            r_rnw        <= w_sel_rnw;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
        end
    end

    // Registered strobes: mem_en for ISSUE, ack to the granted port for CAPTURE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_en   <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_host_ack <= 1'b0;
        end else begin
            r_mem_en   <= (w_next_state == ARB_STATE_ISSUE);
            r_cpu_ack  <= (w_next_state == ARB_STATE_CAPTURE) && (r_grant == ARB_GRANT_CPU);
            r_host_ack <= (w_next_state == ARB_STATE_CAPTURE) && (r_grant == ARB_GRANT_HOST);
        end
    end

    assign w_cap_read = (r_state == ARB_STATE_CAPTURE) && r_rnw;

    // Keep a copy of the RAM read data so it remains visible after the ack cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else if (w_cap_read) begin
            if (r_grant == ARB_GRANT_HOST) begin
                r_host_rdata <= i_mem_rdata;
            end else begin
                r_cpu_rdata  <= i_mem_rdata;
            end
        end
    end

    // During the ack cycle the RAM output is passed straight through so data and ack align.
    always_comb begin
        if (w_cap_read && (r_grant == ARB_GRANT_CPU)) begin
            o_cpu_rdata = i_mem_rdata;
        end else begin
            o_cpu_rdata = r_cpu_rdata;
        end
        if (w_cap_read && (r_grant == ARB_GRANT_HOST)) begin
            o_host_rdata = i_mem_rdata;
        end else begin
            o_host_rdata = r_host_rdata;
        end
    end

    assign o_cpu_ack            = r_cpu_ack;
    assign o_host_ack           = r_host_ack;
    assign o_mem_en             = r_mem_en;
    assign o_mem_read_not_write = r_rnw;
    assign o_mem_addr           = r_addr;
    assign o_mem_wdata          = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized two-port traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_cpu_req, i_cpu_rnw, i_host_req, i_host_rnw;
    logic [7:0]  i_cpu_addr, i_host_addr;
    logic [15:0] i_cpu_wdata, i_host_wdata;
    logic [15:0] o_cpu_rdata, o_host_rdata;
    logic        o_cpu_ack, o_host_ack;
    logic        o_mem_en, o_mem_rnw;
    logic [7:0]  o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model state: pending request per port (0=CPU, 1=host),
    // expected memory contents and expected held read data.
    bit          p_req [2];
    logic        p_rnw [2];
    logic [7:0]  p_addr[2];
    logic [15:0] p_wd  [2];
    logic [15:0] exp_rd[2];
    logic [15:0] sh    [256];
    int          last_win;

    logic [15:0] ram [256];
    bit          ram_init_done = 1'b0;

    mem_port_arbiter dut (
        .i_clk                 (clk),
        .i_reset               (i_reset),
        .i_cpu_req             (i_cpu_req),
        .i_cpu_read_not_write  (i_cpu_rnw),
        .i_cpu_addr            (i_cpu_addr),
        .i_cpu_wdata           (i_cpu_wdata),
        .o_cpu_rdata           (o_cpu_rdata),
        .o_cpu_ack             (o_cpu_ack),
        .i_host_req            (i_host_req),
        .i_host_read_not_write (i_host_rnw),
        .i_host_addr           (i_host_addr),
        .i_host_wdata          (i_host_wdata),
        .o_host_rdata          (o_host_rdata),
        .o_host_ack            (o_host_ack),
        .o_mem_en              (o_mem_en),
        .o_mem_read_not_write  (o_mem_rnw),
        .o_mem_addr            (o_mem_addr),
        .o_mem_wdata           (o_mem_wdata),
        .i_mem_rdata           (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_pat(input int a);
        logic [15:0] v;
        if (a == 16) v = 16'h1234;
        else v = 16'(a * 40503) ^ 16'h5A5A;
        return v;
    endfunction

    // Synchronous single-port RAM: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_pat(i);
            ram_init_done <= 1'b1;
        end else if (o_mem_en) begin
            if (o_mem_rnw) mem_rdata <= ram[o_mem_addr];
            else           ram[o_mem_addr] <= o_mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? o_cpu_ack : o_host_ack;
    endfunction

    function automatic logic [15:0] get_rd(input int p);
        return (p == 0) ? o_cpu_rdata : o_host_rdata;
    endfunction

    task automatic drive_ports();
        i_cpu_req   = p_req[0];
        i_cpu_rnw   = p_rnw[0];
        i_cpu_addr  = p_addr[0];
        i_cpu_wdata = p_wd[0];
        i_host_req   = p_req[1];
        i_host_rnw   = p_rnw[1];
        i_host_addr  = p_addr[1];
        i_host_wdata = p_wd[1];
    endtask

    task automatic new_req(input int p);
        p_req[p]  = 1'b1;
        p_rnw[p]  = 1'($urandom_range(1, 0));
        p_addr[p] = 8'($urandom);
        p_wd[p]   = 16'($urandom);
    endtask

    task automatic set_req(input int p, input logic rnw, input logic [7:0] a, input logic [15:0] d);
        p_req[p]  = 1'b1;
        p_rnw[p]  = rnw;
        p_addr[p] = a;
        p_wd[p]   = d;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"}, o_mem_en, 1'b0);
        chk({tag, "_cack"}, o_cpu_ack, 1'b0);
        chk({tag, "_hack"}, o_host_ack, 1'b0);
        chk({tag, "_crd"}, o_cpu_rdata, exp_rd[0]);
        chk({tag, "_hrd"}, o_host_rdata, exp_rd[1]);
    endtask

    // One complete access, called from an IDLE cycle with at least one port pending.
    task automatic serve(input bit refill);
        int g;
        int o;
        if (p_req[0] && p_req[1]) g = (last_win == 0) ? 1 : 0;
        else if (p_req[0])        g = 0;
        else                      g = 1;
        o = 1 - g;
        last_win = g;
        tick();
        chk("issue_en", o_mem_en, 1'b1);
        chk("issue_rnw", o_mem_rnw, p_rnw[g]);
        chk("issue_addr", o_mem_addr, p_addr[g]);
        if (!p_rnw[g]) chk("issue_wdata", o_mem_wdata, p_wd[g]);
        chk("issue_noack", {o_cpu_ack, o_host_ack}, 2'b00);
        // Requester fields changing mid-access must have no effect.
        if (g == 0) begin
            i_cpu_addr = 8'($urandom); i_cpu_wdata = 16'($urandom); i_cpu_rnw = ~p_rnw[0];
        end else begin
            i_host_addr = 8'($urandom); i_host_wdata = 16'($urandom); i_host_rnw = ~p_rnw[1];
        end
        tick();
        if (p_rnw[g]) exp_rd[g] = sh[p_addr[g]];
        else          sh[p_addr[g]] = p_wd[g];
        chk("cap_ack_granted", get_ack(g), 1'b1);
        chk("cap_ack_other", get_ack(o), 1'b0);
        chk("cap_en", o_mem_en, 1'b0);
        chk("cap_rd_granted", get_rd(g), exp_rd[g]);
        chk("cap_rd_other", get_rd(o), exp_rd[o]);
        p_req[g] = 1'b0;
        if (refill) new_req(g);
        drive_ports();
        tick();
        chk_quiet("idle");
    endtask

    task automatic model_reset();
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        last_win  = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sh[i] = init_pat(i);
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_rnw[p] = 1'b1; p_addr[p] = 8'h00; p_wd[p] = 16'h0000;
        end
        model_reset();
        drive_ports();
        i_reset    = 1'b1;
        i_cpu_req  = 1'b1;
        i_host_req = 1'b1;

        // Reset held two cycles with both requests high.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_quiet("rst");
            chk("rst_rnw", o_mem_rnw, 1'b0);
            chk("rst_addr", o_mem_addr, 8'h00);
            chk("rst_wdata", o_mem_wdata, 16'h0000);
        end
        i_reset = 1'b0;
        drive_ports();

        // CPU read of preloaded word.
        set_req(0, 1'b1, 8'h10, 16'h0000);
        drive_ports();
        serve(1'b0);
        chk("cpu_rd_1234", o_cpu_rdata, 16'h1234);

        // Host write then CPU read of the same word.
        set_req(1, 1'b0, 8'h20, 16'hBEEF);
        drive_ports();
        serve(1'b0);
        set_req(0, 1'b1, 8'h20, 16'h0000);
        drive_ports();
        serve(1'b0);
        chk("cpu_rd_beef", o_cpu_rdata, 16'hBEEF);
        chk("host_rd_untouched", o_host_rdata, 16'h0000);

        // Reset during host ISSUE: access abandoned, issued write persists.
        set_req(1, 1'b0, 8'h40, 16'hCAFE);
        drive_ports();
        tick();
        chk("rst5_issue_en", o_mem_en, 1'b1);
        chk("rst5_issue_addr", o_mem_addr, 8'h40);
        i_reset = 1'b1;
        tick();
        sh[8'h40] = 16'hCAFE;
        model_reset();
        chk_quiet("rst5");
        i_reset = 1'b0;
        p_rnw[1] = 1'b1;
        drive_ports();
        serve(1'b0);
        chk("host_rd_cafe", o_host_rdata, 16'hCAFE);

        // Reset, then both ports held continuously: strict C,H alternation.
        i_reset = 1'b1;
        new_req(0);
        new_req(1);
        drive_ports();
        tick();
        model_reset();
        chk_quiet("rst4");
        i_reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("alt_expect", last_win, (k % 2 == 0) ? 1 : 0);
            serve(1'b1);
        end

        // Randomized traffic from both ports.
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && ($urandom_range(1, 0) == 1)) new_req(p);
            end
            drive_ports();
            if (!p_req[0] && !p_req[1]) begin
                tick();
                chk_quiet("rand_idle");
            end else begin
                serve(1'($urandom_range(1, 0)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
